// File: rtl/boot_loader.sv
// boot_loader: write side of the CPU32 instruction memory.
// Receives a framed byte stream (MAGIC, BASE, COUNT, data words), assembles
// little-endian 32-bit words, writes them to word-addressed instruction RAM,
// and holds the core in reset until the whole image has been written.
// Build option: define BOOT_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte over all data bytes before the core is released.
module boot_loader #(
   parameter logic [7:0]  MAGIC   = 8'hA5,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_rst,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_HDR_ADDR = 3'd1,
      S_HDR_CNT  = 3'd2,
      S_DATA     = 3'd3,
`ifdef BOOT_LOADER_CHECKSUM_EN
      S_CSUM     = 3'd4,
`endif
      S_DONE     = 3'd5
   } state_t;

   localparam logic [31:0] TIMEOUT_W  = TIMEOUT;
   localparam bit          TIMEOUT_ON = (TIMEOUT != 0);

   state_t      state_q, state_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [23:0] shift_q, shift_d;
   logic [31:0] base_q, base_d;
   logic [31:0] count_q, count_d;
   logic [31:0] word_idx_q, word_idx_d;
   logic [31:0] idle_q, idle_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        done_q, done_d;
   logic        cpu_rst_q, cpu_rst_d;
   logic        err_q, err_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
   logic [7:0]  csum_q, csum_d;
`endif

   logic        accept;
   logic        last_byte;
   logic        timed;
   logic [31:0] assembled;
   logic [31:0] idle_inc;

   // The loader never stalls the host; it only refuses bytes during reset.
   assign rx_ready  = ~rst;
   assign accept    = rx_valid & ~rst;
   assign last_byte = (byte_cnt_q == 2'd3);
   assign assembled = {rx_data, shift_q};
   assign idle_inc  = idle_q + 32'd1;

   // Next-state logic: frame parsing, word assembly, RAM writes and idle timeout.
   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      shift_d     = shift_q;
      base_d      = base_q;
      count_d     = count_q;
      word_idx_d  = word_idx_q;
      idle_d      = 32'd0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      done_d      = done_q;
      cpu_rst_d   = cpu_rst_q;
      err_d       = err_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
      csum_d      = csum_q;
`endif
      timed       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept && (rx_data == MAGIC)) begin
               state_d    = S_HDR_ADDR;
               err_d      = 1'b0;
               byte_cnt_d = 2'd0;
`ifdef BOOT_LOADER_CHECKSUM_EN
               csum_d     = 8'h00;
`endif
            end
         end

         S_HDR_ADDR: begin
            timed = 1'b1;
            if (accept) begin
               shift_d    = assembled[31:8];
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (last_byte) begin
                  base_d  = assembled;
                  state_d = S_HDR_CNT;
               end
            end
         end

         S_HDR_CNT: begin
            timed = 1'b1;
            if (accept) begin
               shift_d    = assembled[31:8];
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (last_byte) begin
                  count_d    = assembled;
                  word_idx_d = 32'd0;
                  if (assembled == 32'd0) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                     state_d   = S_CSUM;
`else
                     state_d   = S_DONE;
                     done_d    = 1'b1;
                     cpu_rst_d = 1'b0;
`endif
                  end else begin
                     state_d = S_DATA;
                  end
               end
            end
         end

         S_DATA: begin
            timed = 1'b1;
            if (accept) begin
               shift_d    = assembled[31:8];
               byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
               csum_d     = csum_q ^ rx_data;
`endif
               if (last_byte) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = base_q + word_idx_q;
                  mem_wdata_d = assembled;
                  word_idx_d  = word_idx_q + 32'd1;
                  if (word_idx_q == (count_q - 32'd1)) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                     state_d   = S_CSUM;
`else
                     state_d   = S_DONE;
                     done_d    = 1'b1;
                     cpu_rst_d = 1'b0;
`endif
                  end
               end
            end
         end

`ifdef BOOT_LOADER_CHECKSUM_EN
         S_CSUM: begin
            timed = 1'b1;
            if (accept) begin
               if (rx_data == csum_q) begin
                  state_d   = S_DONE;
                  done_d    = 1'b1;
                  cpu_rst_d = 1'b0;
               end else begin
                  state_d = S_IDLE;
                  err_d   = 1'b1;
               end
            end
         end
`endif

         S_DONE: begin
            if (accept && (rx_data == MAGIC)) begin
               state_d    = S_HDR_ADDR;
               done_d     = 1'b0;
               cpu_rst_d  = 1'b1;
               err_d      = 1'b0;
               byte_cnt_d = 2'd0;
`ifdef BOOT_LOADER_CHECKSUM_EN
               csum_d     = 8'h00;
`endif
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (timed && !accept && TIMEOUT_ON) begin
         idle_d = idle_inc;
         if (idle_inc == TIMEOUT_W) begin
            idle_d     = 32'd0;
            state_d    = S_IDLE;
            err_d      = 1'b1;
            byte_cnt_d = 2'd0;
         end
      end
   end

   // State register with synchronous reset; reset also cancels any pending write.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         byte_cnt_q  <= 2'd0;
         shift_q     <= 24'd0;
         base_q      <= 32'd0;
         count_q     <= 32'd0;
         word_idx_q  <= 32'd0;
         idle_q      <= 32'd0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         done_q      <= 1'b0;
         cpu_rst_q   <= 1'b1;
         err_q       <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
         csum_q      <= 8'h00;
`endif
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         shift_q     <= shift_d;
         base_q      <= base_d;
         count_q     <= count_d;
         word_idx_q  <= word_idx_d;
         idle_q      <= idle_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         done_q      <= done_d;
         cpu_rst_q   <= cpu_rst_d;
         err_q       <= err_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_rst   = cpu_rst_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: self-checking bench for boot_loader.
// Frames are sent by a frame-level driver that also predicts, from the frame
// contents and the edge at which each byte is accepted, when every RAM write
// and every done/err/cpu_rst change must appear. A compare process checks all
// outputs against those predictions on every cycle.
`timescale 1ns/1ps
module tb_boot_loader;

   localparam int unsigned TIMEOUT = 16;
   localparam logic [7:0]  MAGIC   = 8'hA5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_rst;
   logic        done;
   logic        err;

   boot_loader #(.MAGIC(MAGIC), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .cpu_rst(cpu_rst), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int edges = 0;
   always @(posedge clk) edges <= edges + 1;

   typedef struct { int stamp; logic dn; logic er; logic cr; logic clr; } flagEv_t;
   typedef struct { int stamp; logic [31:0] addr; logic [31:0] data; } wrEv_t;
   typedef struct { logic [31:0] addr; logic [31:0] data; } obs_t;

   flagEv_t flagQ[$];
   wrEv_t   wrQ[$];
   obs_t    obsQ[$];

   logic        expDone = 1'b0;
   logic        expErr = 1'b0;
   logic        expCpuRst = 1'b1;
   logic [31:0] expAddr = 32'd0;
   logic [31:0] expData = 32'd0;

   int total = 0;
   int bad = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edges);
      end
   endtask

   task automatic checkLog(input int idx, input logic [31:0] a, input logic [31:0] d, input string name);
      if (idx >= obsQ.size()) begin
         total++;
         bad++;
         $display("[TB] FAIL %s: got %0d writes expected at least %0d", name, obsQ.size(), idx + 1);
      end else begin
         checkOutput({name, "_addr"}, obsQ[idx].addr, a);
         checkOutput({name, "_data"}, obsQ[idx].data, d);
      end
   endtask

   task automatic pushFlag(input int s, input logic dn, input logic er, input logic cr, input logic clr);
      flagEv_t ev;
      ev.stamp = s; ev.dn = dn; ev.er = er; ev.cr = cr; ev.clr = clr;
      flagQ.push_back(ev);
   endtask

   // Drives one byte; stamp is the edge that will accept it.
   task automatic applyStimulus(input logic [7:0] b, input logic withRst, output int stamp);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      rst      = withRst;
      stamp    = edges + 1;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rx_valid = 1'b0;
         rst      = 1'b0;
      end
   endtask

   task automatic applyReset();
      int s;
      @(negedge clk);
      rst      = 1'b1;
      rx_valid = 1'b0;
      s        = edges + 1;
      pushFlag(s, 1'b0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Completion of an image: direct release, or a checksum byte first.
   task automatic finishLoad(input int stamp, input logic [7:0] x, input int csumOverride);
`ifdef BOOT_LOADER_CHECKSUM_EN
      logic [7:0] c;
      int s;
      c = (csumOverride < 0) ? x : csumOverride[7:0];
      applyStimulus(c, 1'b0, s);
      if (c == x) pushFlag(s, 1'b1, 1'b0, 1'b0, 1'b0);
      else        pushFlag(s, 1'b0, 1'b1, 1'b1, 1'b0);
      idleCycles(1);
`else
      if (csumOverride < -1 || x === 8'hxx) $display("[TB] note: checksum argument ignored");
      pushFlag(stamp, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
   endtask

   // Sends a whole frame and predicts its effects.
   task automatic sendFrame(input logic [31:0] base, input logic [31:0] n, input logic [7:0] data[$],
                            input int stallAt, input int rstAt, input int csumOverride);
      int s;
      int last;
      logic [7:0] x;
      wrEv_t w;
      x = 8'h00;
      applyStimulus(MAGIC, 1'b0, s);
      pushFlag(s, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(base[8*i +: 8], 1'b0, s);
      for (int i = 0; i < 4; i++) applyStimulus(n[8*i +: 8], 1'b0, s);
      last = s;
      if (n == 32'd0) begin
         finishLoad(last, x, csumOverride);
         return;
      end
      for (int i = 0; i < data.size(); i++) begin
         if (i == stallAt) break;
         if (i == rstAt) begin
            applyStimulus(data[i], 1'b1, s);
            pushFlag(s, 1'b0, 1'b0, 1'b1, 1'b1);
            idleCycles(1);
            return;
         end
         applyStimulus(data[i], 1'b0, s);
         x    = x ^ data[i];
         last = s;
         if (i % 4 == 3) begin
            w.stamp = s;
            w.addr  = base + 32'(i / 4);
            w.data  = {data[i], data[i-1], data[i-2], data[i-3]};
            wrQ.push_back(w);
            if (32'(i / 4) == n - 32'd1) finishLoad(s, x, csumOverride);
         end
      end
      if (stallAt >= 0) begin
         pushFlag(last + int'(TIMEOUT), 1'b0, 1'b1, 1'b1, 1'b0);
         idleCycles(int'(TIMEOUT) + 4);
      end
   endtask

   // Per-cycle comparison of all outputs against the predicted behaviour.
   always begin
      obs_t o;
      @(negedge clk);
      #1;
      while (flagQ.size() > 0 && flagQ[0].stamp <= edges) begin
         expDone   = flagQ[0].dn;
         expErr    = flagQ[0].er;
         expCpuRst = flagQ[0].cr;
         if (flagQ[0].clr) begin
            expAddr = 32'd0;
            expData = 32'd0;
         end
         flagQ.delete(0);
      end
      if (mem_we === 1'b1) begin
         o.addr = mem_addr;
         o.data = mem_wdata;
         obsQ.push_back(o);
      end
      if (wrQ.size() > 0 && wrQ[0].stamp <= edges) begin
         checkOutput("mem_we", {31'd0, mem_we}, 32'd1);
         checkOutput("mem_addr", mem_addr, wrQ[0].addr);
         checkOutput("mem_wdata", mem_wdata, wrQ[0].data);
         expAddr = wrQ[0].addr;
         expData = wrQ[0].data;
         wrQ.delete(0);
      end else begin
         checkOutput("mem_we_low", {31'd0, mem_we}, 32'd0);
         checkOutput("mem_addr_hold", mem_addr, expAddr);
         checkOutput("mem_wdata_hold", mem_wdata, expData);
      end
      checkOutput("done", {31'd0, done}, {31'd0, expDone});
      checkOutput("err", {31'd0, err}, {31'd0, expErr});
      checkOutput("cpu_rst", {31'd0, cpu_rst}, {31'd0, expCpuRst});
      checkOutput("rx_ready", {31'd0, rx_ready}, {31'd0, ~rst});
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] q[$];
      int o;
      int s;

      rst = 1'b1;
      idleCycles(2);
      checkOutput("reset_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      checkOutput("reset_done", {31'd0, done}, 32'd0);
      checkOutput("reset_err", {31'd0, err}, 32'd0);
      checkOutput("reset_mem_we", {31'd0, mem_we}, 32'd0);
      checkOutput("reset_addr", mem_addr, 32'd0);

      // Basic two-word image at base 0.
      $display("[TB] frame: two words at base 0");
      o = obsQ.size();
      q = '{8'h88, 8'h48, 8'h01, 8'h00, 8'hAF, 8'hBE, 8'hAD, 8'hDE};
      sendFrame(32'h0, 32'd2, q, -1, -1, -1);
      idleCycles(3);
      checkLog(o, 32'h0, 32'h00014888, "f1_w0");
      checkLog(o + 1, 32'h1, 32'hDEADBEAF, "f1_w1");
      checkOutput("f1_done", {31'd0, done}, 32'd1);
      checkOutput("f1_cpu_rst", {31'd0, cpu_rst}, 32'd0);
      checkOutput("f1_err", {31'd0, err}, 32'd0);

      // Garbage in IDLE, then a single word at 0x132.
      $display("[TB] frame: garbage then base 0x132");
      applyReset();
      applyStimulus(8'h00, 1'b0, s);
      applyStimulus(8'hFF, 1'b0, s);
      applyStimulus(8'h13, 1'b0, s);
      o = obsQ.size();
      q = '{8'h00, 8'h00, 8'h00, 8'h40};
      sendFrame(32'h132, 32'd1, q, -1, -1, -1);
      idleCycles(3);
      checkLog(o, 32'h132, 32'h40000000, "f2_w0");
      checkOutput("f2_count", obsQ.size() - o, 32'd1);

      // Address wrap from the top of the address space.
      $display("[TB] frame: address wrap");
      o = obsQ.size();
      q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      sendFrame(32'hFFFFFFFF, 32'd2, q, -1, -1, -1);
      idleCycles(3);
      checkLog(o, 32'hFFFFFFFF, 32'h04030201, "wrap_w0");
      checkLog(o + 1, 32'h00000000, 32'h08070605, "wrap_w1");

      // Empty image.
      $display("[TB] frame: N=0");
      o = obsQ.size();
      q.delete();
      sendFrame(32'h5, 32'd0, q, -1, -1, -1);
      idleCycles(3);
      checkOutput("n0_count", obsQ.size() - o, 32'd0);
      checkOutput("n0_done", {31'd0, done}, 32'd1);

      // Stall inside a word until the idle timeout fires.
      $display("[TB] frame: timeout");
      o = obsQ.size();
      q = '{8'h11, 8'h22, 8'h33, 8'h44};
      sendFrame(32'h20, 32'd1, q, 2, -1, -1);
      checkOutput("to_err", {31'd0, err}, 32'd1);
      checkOutput("to_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      checkOutput("to_done", {31'd0, done}, 32'd0);
      checkOutput("to_count", obsQ.size() - o, 32'd0);

      // Recovery from error, then a reload from DONE.
      $display("[TB] frame: recovery and reload");
      o = obsQ.size();
      q = '{8'h11, 8'h22, 8'h33, 8'h44};
      sendFrame(32'h40, 32'd1, q, -1, -1, -1);
      idleCycles(2);
      checkLog(o, 32'h40, 32'h44332211, "rec_w0");
      checkOutput("rec_err", {31'd0, err}, 32'd0);
      q = '{8'h11, 8'h00, 8'h00, 8'h00};
      sendFrame(32'h10, 32'd1, q, -1, -1, -1);
      idleCycles(2);
      checkLog(o + 1, 32'h10, 32'h00000011, "reload_w0");
      checkOutput("reload_done", {31'd0, done}, 32'd1);

      // Reset on the last byte of word 0 suppresses the write.
      $display("[TB] frame: reset mid-frame");
      o = obsQ.size();
      q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h01, 8'h02, 8'h03, 8'h04};
      sendFrame(32'h50, 32'd2, q, -1, 3, -1);
      idleCycles(3);
      checkOutput("mrst_count", obsQ.size() - o, 32'd0);
      checkOutput("mrst_addr", mem_addr, 32'd0);
      checkOutput("mrst_data", mem_wdata, 32'd0);
      checkOutput("mrst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      checkOutput("mrst_done", {31'd0, done}, 32'd0);

`ifdef BOOT_LOADER_CHECKSUM_EN
      // Checksum accepted, then checksum rejected.
      $display("[TB] frame: checksum");
      q = '{8'h01, 8'h02, 8'h03, 8'h04};
      sendFrame(32'h60, 32'd1, q, -1, -1, 8'h04);
      idleCycles(2);
      checkOutput("cs_ok_done", {31'd0, done}, 32'd1);
      checkOutput("cs_ok_err", {31'd0, err}, 32'd0);
      sendFrame(32'h60, 32'd1, q, -1, -1, 8'h05);
      idleCycles(2);
      checkOutput("cs_bad_err", {31'd0, err}, 32'd1);
      checkOutput("cs_bad_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      checkOutput("cs_bad_done", {31'd0, done}, 32'd0);
`endif

      idleCycles(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Byte-stream program loader: the write side of the CPU32 instruction memory.
- Accepts a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them to word-addressed instruction RAM.
- Holds the core in reset until the image is written, then releases it.
- Sits between a host link (UART/bench) and the instruction RAM port / `test_processor_assembly` reset input.

Parameters:
- MAGIC, 8'hA5, frame start byte.
- TIMEOUT, 1024, max idle cycles between accepted bytes inside a frame; 0 disables timeout.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader accepts byte; a byte transfers when rx_valid & rx_ready on a rising edge
- mem_we  output  1  one-cycle instruction RAM write strobe
- mem_addr  output  32  word address (pc units)
- mem_wdata  output  32  instruction word
- cpu_rst  output  1  core reset; high while not loaded
- done  output  1  image loaded, core running
- err  output  1  sticky frame error

Behaviour:
- Reset, while rst=1 and the cycle after:
  - state IDLE; cpu_rst=1.
  - mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0.
  - rx_ready=0 while rst=1, otherwise 1 in every state. The loader never stalls.
- Frame format:
  - MAGIC.
  - BASE: 4 bytes, little-endian.
  - COUNT N: 4 bytes, little-endian.
  - 4N data bytes: each word little-endian, first byte = bits [7:0].
- States:
  - IDLE: non-MAGIC bytes are accepted and discarded. MAGIC -> HDR_ADDR; clears err; byte counter=0.
  - HDR_ADDR: 4 bytes -> BASE -> HDR_CNT.
  - HDR_CNT: 4 bytes -> N.
    - N=0 -> DONE.
    - Otherwise -> DATA, with word index k=0.
  - DATA: shift bytes into the word assembler. On acceptance of the 4th byte of word k, the next cycle has:
    - mem_we=1, mem_addr=BASE+k (mod 2^32, wraps silently), mem_wdata=assembled word.
    - Write latency is exactly 1 cycle after the accepting edge; mem_we is low otherwise.
    - After word N-1 is written -> DONE (or CSUM when the checksum option is built in).
  - DONE: done=1, cpu_rst=0, both registered, asserted the same cycle the last mem_we is asserted (or CSUM passes).
    - Non-MAGIC bytes are discarded.
    - MAGIC restarts: next cycle done=0, cpu_rst=1, state HDR_ADDR.
- mem_addr/mem_wdata hold their last value when mem_we=0.
- Counters: byte-in-word 2 bits; word index k is 32 bits, compared against N; N up to 2^32-1.
- Timeout: only in HDR_ADDR, HDR_CNT, DATA, CSUM.
  - The idle counter resets on every accepted byte.
  - When it reaches TIMEOUT with no byte accepted -> err=1, state IDLE, cpu_rst stays 1, partial word dropped.
  - Words already written remain in RAM.
- Synchronous rst mid-frame: aborts to reset state immediately. A write strobe due the following cycle is suppressed.
- A byte arriving in the same cycle as rst is not accepted.

Optional Feature:
- Macro: BOOT_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data byte, state CSUM expects one byte equal to the XOR of all 4N data bytes (header excluded).
  - Match -> DONE.
  - Mismatch -> err=1, IDLE, cpu_rst stays 1.
  - N=0 also expects a checksum byte of 8'h00.
  - Timeout applies in CSUM.
- Undefined: no CSUM state; DATA -> DONE directly; no checksum logic is synthesized.

Test Plan:
- Reset then frame A5, BASE 00000000, N 00000002, data 88 48 01 00, AF BE AD DE -> mem_we pulses at addr 0 wdata 00014888, then addr 1 wdata DEADBEAF; done=1 and cpu_rst=0 on the second write cycle; err=0.
- Garbage bytes 00 FF 13 before A5, BASE 00000132, N 1, data 00 00 00 40 -> garbage ignored; a single write at addr 132 wdata 40000000.
- BASE FFFFFFFF, N 2 -> writes at FFFFFFFF then 00000000 (wrap); N=0 frame -> no mem_we, done=1 immediately after the header.
- TIMEOUT=16: send A5, BASE, N=1, two data bytes, then stall 20 cycles -> err=1 at idle count 16, no mem_we, cpu_rst=1; next A5 clears err.
- After DONE, send a second frame A5 BASE 10 N 1 data 11 00 00 00 -> cpu_rst=1 and done=0 the cycle after MAGIC; write at addr 10 wdata 11; done again. Assert rst during word 0 byte 3 of another frame -> no write, all outputs return to reset values.
- With BOOT_LOADER_CHECKSUM_EN: data 01 02 03 04 plus checksum 04 -> done; checksum 05 -> err=1, cpu_rst stays 1.
